// File: rtl/irq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package : irq_pkg                                                  |
// | Shared sizes, types and per-vector config record for irq_scheduler |
// | Rev     : 1.0                                                      |
// +--------------------------------------------------------------------+
package irq_pkg;

   localparam int VecLen     = 8;
   localparam int PrioWidth  = 3;
   localparam int StackDepth = 4;
   localparam int IdxWidth   = $clog2(VecLen);
   localparam int DepthWidth = $clog2(StackDepth + 1);
   localparam int StackAw    = $clog2(StackDepth);

   typedef logic [PrioWidth-1:0]  prio_t;
   typedef logic [IdxWidth-1:0]   vec_idx_t;
   typedef logic [DepthWidth-1:0] depth_t;

   typedef struct packed {
      logic  en;
      prio_t prio;
   } vec_cfg_t;

   localparam depth_t DepthMax = depth_t'(StackDepth);

endpackage : irq_pkg
`default_nettype wire

// File: rtl/irq_level_stack.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : irq_level_stack                                           |
// | Saved execution levels for nested interrupts; pop wins over push   |
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
module irq_level_stack
   import irq_pkg::*;
(
   input  logic   clk,
   input  logic   reset,
   input  logic   push,
   input  logic   pop,
   input  prio_t  push_val,
   output prio_t  top,
   output depth_t depth,
   output logic   full,
   output logic   empty
);

   prio_t               r_stack [StackDepth];
   depth_t              r_depth;
   depth_t              w_depth_m1;
   logic [StackAw-1:0]  w_wr_idx;
   logic [StackAw-1:0]  w_top_idx;

   assign full       = (r_depth == DepthMax);
   assign empty      = (r_depth == '0);
   assign w_depth_m1 = r_depth - depth_t'(1);
   assign w_wr_idx   = r_depth[StackAw-1:0];
   assign w_top_idx  = w_depth_m1[StackAw-1:0];
   assign top        = r_stack[w_top_idx];
   assign depth      = r_depth;

   // Full/empty guards keep the index in range; no wrap-around.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_depth <= '0;
         for (int i = 0; i < StackDepth; i++) begin
            r_stack[i] <= '0;
         end
      end else if (pop && !empty) begin
         r_depth <= w_depth_m1;
      end else if (push && !full) begin
         r_stack[w_wr_idx] <= push_val;
         r_depth           <= r_depth + depth_t'(1);
      end
   end

endmodule : irq_level_stack
`default_nettype wire

// File: rtl/irq_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : irq_scheduler                                             |
// | Edge-latched priority interrupt scheduler with nesting level stack |
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
module irq_scheduler
   import irq_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [VecLen-1:0] irq_in,
   input  logic              cfg_we,
   input  vec_idx_t          cfg_idx,
   input  logic              cfg_en,
   input  prio_t             cfg_prio,
   input  logic              take,
   input  logic              ret,
   output logic              req,
   output vec_idx_t          id,
   output prio_t             level,
   output depth_t            depth,
   output logic              overflow
);

   logic [VecLen-1:0] r_irq_q;
   logic [VecLen-1:0] r_pending;
   vec_cfg_t          r_cfg [VecLen];
   prio_t             r_level;
   logic              r_overflow;

   logic [VecLen-1:0] w_edge;
   logic [VecLen-1:0] w_eligible;
   logic [VecLen-1:0] w_clear;
   logic              w_any_elig;
   logic              w_found;
   prio_t             w_best_prio;
   vec_idx_t          w_best_id;
   logic              w_take;
   logic              w_full;
   logic              w_empty;
   prio_t             w_top;

   assign w_edge = irq_in & ~r_irq_q;

   always_comb begin
      w_eligible = '0;
      for (int i = 0; i < VecLen; i++) begin
         w_eligible[i] = r_pending[i] && r_cfg[i].en &&
                         (r_cfg[i].prio > r_level) && (r_cfg[i].prio != '0);
      end
   end

   // Strict greater-than keeps the lowest index on priority ties.
   always_comb begin
      w_found     = 1'b0;
      w_best_prio = '0;
      w_best_id   = '0;
      for (int i = 0; i < VecLen; i++) begin
         if (w_eligible[i] && (!w_found || (r_cfg[i].prio > w_best_prio))) begin
            w_found     = 1'b1;
            w_best_prio = r_cfg[i].prio;
            w_best_id   = vec_idx_t'(i);
         end
      end
   end

   assign w_any_elig = |w_eligible;
   assign req        = w_any_elig && !w_full;
   assign w_take     = take && req && !ret;

   always_comb begin
      w_clear = '0;
      if (w_take) begin
         w_clear[w_best_id] = 1'b1;
      end
   end

   irq_level_stack u_stack (
      .clk      (clk),
      .reset    (reset),
      .push     (w_take),
      .pop      (ret),
      .push_val (r_level),
      .top      (w_top),
      .depth    (depth),
      .full     (w_full),
      .empty    (w_empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_irq_q    <= '0;
         r_pending  <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
         for (int i = 0; i < VecLen; i++) begin
            r_cfg[i] <= '0;
         end
      end else begin
         r_irq_q   <= irq_in;
         // A fresh edge on the vector being taken survives the clear.
         r_pending <= (r_pending & ~w_clear) | w_edge;
         if (cfg_we) begin
            r_cfg[cfg_idx] <= '{en: cfg_en, prio: cfg_prio};
         end
         if (ret && !w_empty) begin
            r_level <= w_top;
         end else if (w_take) begin
            r_level <= r_cfg[w_best_id].prio;
         end
         if (take && !req && w_full && w_any_elig) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign id       = w_best_id;
   assign level    = r_level;
   assign overflow = r_overflow;

endmodule : irq_scheduler
`default_nettype wire

// File: tb/tb_irq_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_irq_scheduler                                          |
// | Directed self-checking bench for irq_scheduler                     |
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_irq_scheduler;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] irq_in = '0;
   logic       cfg_we = 1'b0;
   logic [2:0] cfg_idx = '0;
   logic       cfg_en = 1'b0;
   logic [2:0] cfg_prio = '0;
   logic       take = 1'b0;
   logic       ret = 1'b0;
   logic       req;
   logic [2:0] id;
   logic [2:0] level;
   logic [2:0] depth;
   logic       overflow;

   int checks = 0;
   int errors = 0;

   irq_scheduler dut (
      .clk      (clk),
      .reset    (reset),
      .irq_in   (irq_in),
      .cfg_we   (cfg_we),
      .cfg_idx  (cfg_idx),
      .cfg_en   (cfg_en),
      .cfg_prio (cfg_prio),
      .take     (take),
      .ret      (ret),
      .req      (req),
      .id       (id),
      .level    (level),
      .depth    (depth),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input int idx, input logic en, input int prio);
      cfg_we   = 1'b1;
      cfg_idx  = 3'(idx);
      cfg_en   = en;
      cfg_prio = 3'(prio);
      tick();
      cfg_we   = 1'b0;
   endtask

   task automatic pulse(input logic [7:0] mask);
      irq_in = mask;
      tick();
      irq_in = '0;
   endtask

   task automatic do_take();
      take = 1'b1;
      tick();
      take = 1'b0;
   endtask

   task automatic do_ret();
      ret = 1'b1;
      tick();
      ret = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
      checks++; if (req !== 1'b0)      begin errors++; $display("FAIL rst_req: got %0d required 0", req); end
      checks++; if (id !== 3'd0)       begin errors++; $display("FAIL rst_id: got %0d required 0", id); end
      checks++; if (level !== 3'd0)    begin errors++; $display("FAIL rst_level: got %0d required 0", level); end
      checks++; if (depth !== 3'd0)    begin errors++; $display("FAIL rst_depth: got %0d required 0", depth); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %0d required 0", overflow); end
   endtask

   task automatic test_single();
      cfg(3, 1'b1, 2);
      tick();
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL single_idle_req: got %0d required 0", req); end
      pulse(8'h08);
      checks++; if (req !== 1'b1) begin errors++; $display("FAIL single_req: got %0d required 1", req); end
      checks++; if (id !== 3'd3)  begin errors++; $display("FAIL single_id: got %0d required 3", id); end
      do_take();
      checks++; if (level !== 3'd2) begin errors++; $display("FAIL single_take_level: got %0d required 2", level); end
      checks++; if (depth !== 3'd1) begin errors++; $display("FAIL single_take_depth: got %0d required 1", depth); end
      checks++; if (req !== 1'b0)   begin errors++; $display("FAIL single_take_req: got %0d required 0", req); end
      do_ret();
      checks++; if (level !== 3'd0) begin errors++; $display("FAIL single_ret_level: got %0d required 0", level); end
      checks++; if (depth !== 3'd0) begin errors++; $display("FAIL single_ret_depth: got %0d required 0", depth); end
      do_ret();
      checks++; if (depth !== 3'd0 || level !== 3'd0) begin errors++; $display("FAIL ret_at_empty: got depth %0d level %0d required 0 0", depth, level); end
   endtask

   task automatic test_prio_tie();
      cfg(1, 1'b1, 4);
      cfg(2, 1'b1, 4);
      cfg(5, 1'b1, 6);
      pulse(8'h26);
      checks++; if (req !== 1'b1 || id !== 3'd5) begin errors++; $display("FAIL tie_first: got req %0d id %0d required 1 5", req, id); end
      do_take();
      checks++; if (level !== 3'd6 || req !== 1'b0) begin errors++; $display("FAIL tie_take5: got level %0d req %0d required 6 0", level, req); end
      do_ret();
      checks++; if (req !== 1'b1 || id !== 3'd1) begin errors++; $display("FAIL tie_after_ret: got req %0d id %0d required 1 1", req, id); end
      do_take();
      checks++; if (level !== 3'd4 || req !== 1'b0) begin errors++; $display("FAIL tie_take1: got level %0d req %0d required 4 0", level, req); end
      do_ret();
      checks++; if (req !== 1'b1 || id !== 3'd2) begin errors++; $display("FAIL tie_second: got req %0d id %0d required 1 2", req, id); end
      do_take();
      do_ret();
      checks++; if (req !== 1'b0 || depth !== 3'd0) begin errors++; $display("FAIL tie_drained: got req %0d depth %0d required 0 0", req, depth); end
   endtask

   task automatic test_simultaneous();
      pulse(8'h08);
      do_take();
      pulse(8'h20);
      checks++; if (req !== 1'b1 || id !== 3'd5) begin errors++; $display("FAIL sim_pre: got req %0d id %0d required 1 5", req, id); end
      take = 1'b1;
      ret  = 1'b1;
      tick();
      take = 1'b0;
      ret  = 1'b0;
      checks++; if (depth !== 3'd0 || level !== 3'd0) begin errors++; $display("FAIL take_ret_pop: got depth %0d level %0d required 0 0", depth, level); end
      checks++; if (req !== 1'b1 || id !== 3'd5) begin errors++; $display("FAIL take_ret_persist: got req %0d id %0d required 1 5", req, id); end
      do_take();
      checks++; if (level !== 3'd6 || depth !== 3'd1) begin errors++; $display("FAIL take_ret_retake: got level %0d depth %0d required 6 1", level, depth); end
      do_ret();
      pulse(8'h08);
      tick();
      irq_in = 8'h08;
      take   = 1'b1;
      tick();
      take   = 1'b0;
      irq_in = '0;
      checks++; if (level !== 3'd2 || req !== 1'b0) begin errors++; $display("FAIL edge_in_take: got level %0d req %0d required 2 0", level, req); end
      do_ret();
      checks++; if (req !== 1'b1 || id !== 3'd3) begin errors++; $display("FAIL edge_kept_pending: got req %0d id %0d required 1 3", req, id); end
      do_take();
      do_ret();
   endtask

   task automatic test_cfg_race();
      pulse(8'h08);
      take     = 1'b1;
      cfg_we   = 1'b1;
      cfg_idx  = 3'd3;
      cfg_en   = 1'b1;
      cfg_prio = 3'd7;
      tick();
      take   = 1'b0;
      cfg_we = 1'b0;
      checks++; if (level !== 3'd2 || depth !== 3'd1) begin errors++; $display("FAIL cfg_race_level: got level %0d depth %0d required 2 1", level, depth); end
      do_ret();
      cfg(3, 1'b1, 2);
      pulse(8'h08);
      checks++; if (req !== 1'b1) begin errors++; $display("FAIL disable_pre: got %0d required 1", req); end
      cfg(3, 1'b0, 2);
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL disable_req: got %0d required 0", req); end
      cfg(3, 1'b1, 2);
      checks++; if (req !== 1'b1 || id !== 3'd3) begin errors++; $display("FAIL reenable_req: got req %0d id %0d required 1 3", req, id); end
      do_take();
      do_ret();
   endtask

   task automatic test_nesting_overflow();
      for (int k = 0; k < 5; k++) begin
         cfg(k, 1'b1, k + 1);
      end
      cfg(5, 1'b0, 0);
      for (int k = 0; k < 4; k++) begin
         pulse(8'(1 << k));
         checks++; if (req !== 1'b1 || id !== 3'(k)) begin errors++; $display("FAIL nest_req%0d: got req %0d id %0d required 1 %0d", k, req, id, k); end
         do_take();
         checks++; if (level !== 3'(k + 1) || depth !== 3'(k + 1)) begin errors++; $display("FAIL nest_take%0d: got level %0d depth %0d required %0d %0d", k, level, depth, k + 1, k + 1); end
      end
      pulse(8'h10);
      checks++; if (req !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL full_blocks_req: got req %0d ovf %0d required 0 0", req, overflow); end
      do_take();
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %0d required 1", overflow); end
      checks++; if (level !== 3'd4 || depth !== 3'd4) begin errors++; $display("FAIL overflow_state: got level %0d depth %0d required 4 4", level, depth); end
      do_ret();
      checks++; if (level !== 3'd3 || req !== 1'b1 || id !== 3'd4) begin errors++; $display("FAIL tail_chain: got level %0d req %0d id %0d required 3 1 4", level, req, id); end
      do_ret();
      do_ret();
      do_ret();
      checks++; if (level !== 3'd0 || depth !== 3'd0 || overflow !== 1'b1) begin errors++; $display("FAIL unwind: got level %0d depth %0d ovf %0d required 0 0 1", level, depth, overflow); end
   endtask

   task automatic test_reset_mid();
      do_take();
      do_ret();
      pulse(8'h08);
      do_take();
      pulse(8'h10);
      do_take();
      pulse(8'h0F);
      checks++; if (level !== 3'd5 || depth !== 3'd2 || req !== 1'b0) begin errors++; $display("FAIL mid_setup: got level %0d depth %0d req %0d required 5 2 0", level, depth, req); end
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      checks++; if (req !== 1'b0 || level !== 3'd0 || depth !== 3'd0 || overflow !== 1'b0) begin errors++; $display("FAIL async_reset: got req %0d level %0d depth %0d ovf %0d required 0 0 0 0", req, level, depth, overflow); end
      tick();
      reset = 1'b0;
      cfg(0, 1'b1, 1);
      cfg(2, 1'b1, 3);
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_pending_clear: got %0d required 0", req); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_prio_tie();
      test_simultaneous();
      test_cfg_race();
      test_nesting_overflow();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_irq_scheduler
`default_nettype wire
